// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYC = 40000,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(TIMEOUT_CYC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_data_in,
  output logic                       start,
  input  logic                       done_tx,
  output logic [IW-1:0]              grant_id,
  output logic                       busy,
  output logic                       timeout_err
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        last_q, gid_q, win_d;
  logic [IW:0]          idx;
  logic                 hit_d, start_q, busy_q, terr_q;
  logic [NUM_REQ-1:0]   ready_q;
  logic [DATA_W-1:0]    data_q;
  // scan from the farthest candidate down so the nearest one after last_q wins
  always_comb begin
    win_d = '0;
    hit_d = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, last_q} + (IW+1)'(k);
      idx = (idx >= (IW+1)'(NUM_REQ)) ? idx - (IW+1)'(NUM_REQ) : idx;
      if (req_valid[idx[IW-1:0]]) begin
        win_d = idx[IW-1:0];
        hit_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(NUM_REQ-1);
      gid_q   <= '0;
      data_q  <= '0;
      ready_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      ready_q <= '0;
      terr_q  <= 1'b0;
      case (state_q)
        IDLE: if (hit_d) begin
          data_q  <= req_data[win_d*DATA_W +: DATA_W];
          gid_q   <= win_d;
          last_q  <= win_d;
          ready_q <= NUM_REQ'(1) << win_d;
          start_q <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= LAUNCH;
        end
        LAUNCH: state_q <= WAIT_DONE;
        WAIT_DONE: if (done_tx) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end else if (cnt_q == CW'(TIMEOUT_CYC-1)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          terr_q  <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready   = ready_q;
  assign tx_data_in  = data_q;
  assign start       = start_q;
  assign grant_id    = gid_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random producers/transmitter stub checked against a transaction timeline model
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, TO = 50;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0] tx_data_in;
  logic start, done_tx, busy, timeout_err;
  logic [1:0] grant_id;
  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data_in(tx_data_in), .start(start), .done_tx(done_tx), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  logic [W-1:0] fifo [N][2048];
  int head [N], tail [N];
  int dly_q [$], gl [$], dl [$];
  int e = 0, done_at = -1, st_e = 0, n_terr = 0;
  bit m_active, x_start, x_terr, x_busy, rand_mode = 0, force_done = 0;
  int m_g, m_last, m_gid;
  logic [W-1:0] m_dat;
  logic [N-1:0] x_ready;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) if (v[(last+k)%N]) return (last+k)%N;
    return 0;
  endfunction

  function automatic int next_dly();
    int r;
    if (dly_q.size() != 0) return dly_q.pop_front();
    r = $urandom_range(0, 9);
    return r == 0 ? -1 : r == 1 ? TO+1 : r == 2 ? 1 : r == 3 ? 2 : int'($urandom_range(3, 30));
  endfunction

  task automatic push(int i, logic [W-1:0] b);
    fifo[i][tail[i]] = b;
    tail[i]++;
  endtask

  task automatic reset_model();
    m_active = 0; m_last = N-1; m_gid = 0; m_dat = '0; done_at = -1;
  endtask

  // Rise rst mid-cycle, check outputs clear without a clock edge, release on the next falling edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_start", start, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_data", tx_data_in, 0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  task automatic drive();
    bit has;
    for (int i = 0; i < N; i++) begin
      has = tail[i] != head[i];
      req_valid[i] = has && (!rand_mode || $urandom_range(0, 3) != 0);
      req_data[i*W +: W] = has ? fifo[i][head[i]] : W'($urandom);
    end
    done_tx = (e+1 == done_at) || (!m_active && (force_done || (rand_mode && $urandom_range(0, 15) == 0)));
  endtask

  // Transaction timeline: grant at edge g, done only counts from edge g+2, watchdog fires at edge g+1+TO
  task automatic model(int en);
    x_start = 0; x_terr = 0; x_ready = '0;
    if (m_active) begin
      if (en >= m_g+2 && done_tx) m_active = 0;
      else if (en == m_g+1+TO) begin m_active = 0; x_terr = 1; end
    end else if (req_valid != '0) begin
      m_last = rr_pick(req_valid, m_last);
      m_gid = m_last;
      m_dat = fifo[m_last][head[m_last]];
      m_active = 1; m_g = en; x_start = 1; x_ready = N'(1) << m_last;
    end
    x_busy = m_active;
  endtask

  task automatic cycle();
    int d;
    drive();
    model(e+1);
    @(posedge clk);
    e++;
    @(negedge clk);
    chk("start", start, x_start);
    chk("req_ready", req_ready, x_ready);
    chk("busy", busy, x_busy);
    chk("timeout_err", timeout_err, x_terr);
    chk("grant_id", grant_id, m_gid);
    chk("tx_data_in", tx_data_in, m_dat);
    if (start) begin gl.push_back(grant_id); dl.push_back(tx_data_in); st_e = e; end
    if (timeout_err) begin n_terr++; chk("timeout_latency", e - st_e, TO+1); end
    if (x_start) begin
      head[m_gid]++;
      d = next_dly();
      done_at = d < 0 ? -1 : e + d;
    end
    if (rand_mode)
      for (int i = 0; i < N; i++)
        if (tail[i] - head[i] < 3 && $urandom_range(0, 7) == 0) push(i, W'($urandom));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    req_valid = '0; req_data = '0; done_tx = 1'b0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    reset_model();
    repeat (2) @(negedge clk);
    do_reset();
    push(0, 8'hA5); dly_q.push_back(20); run(30);
    chk("s1_count", gl.size(), 1);
    chk("s1_data", dl[0], 8'hA5);
    do_reset(); gl.delete(); dl.delete();
    for (int i = 0; i < N; i++) begin push(i, W'((i+1)*8'h11)); dly_q.push_back(5); end
    run(40);
    chk("s2_count", gl.size(), 4);
    for (int i = 0; i < 4 && i < gl.size(); i++) begin
      chk("s2_gid", gl[i], i);
      chk("s2_data", dl[i], (i+1)*8'h11);
    end
    gl.delete(); dl.delete();
    push(2, 8'h5A); dly_q.push_back(4); run(10);
    gl.delete();
    push(0, 8'h0F); push(3, 8'hF3); dly_q.push_back(4); dly_q.push_back(4); run(20);
    chk("s3_count", gl.size(), 2);
    chk("s3_first", gl[0], 3);
    chk("s3_second", gl[1], 0);
    gl.delete(); n_terr = 0;
    push(0, 8'h3C); dly_q.push_back(-1); run(3);
    push(1, 8'h4D); dly_q.push_back(3); run(60);
    chk("s4_timeouts", n_terr, 1);
    chk("s4_order", gl.size() == 2 ? gl[1] : 9, 1);
    gl.delete();
    force_done = 1; run(5); force_done = 0;
    chk("s5_no_start", gl.size(), 0);
    push(3, 8'hC3); dly_q.push_back(-1); run(10);
    push(1, 8'h77); run(3);
    gl.delete(); dl.delete();
    do_reset();
    dly_q.push_back(4); run(10);
    chk("s6_regrant", gl.size() == 1 ? gl[0] : 9, 1);
    chk("s6_data", dl.size() == 1 ? dl[0] : 0, 8'h77);
    rand_mode = 1;
    run(2500);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
